// File: rtl/mouse_region_ctl.sv
// Programs a mouse controller's cursor window from a table of regions, with optional recentre.
// Writes are strobed one per (GAP_CYCLES+1) cycles; requests made while busy merge into a single pending re-run.
module mouse_region_ctl #(
  parameter int NUM_REGIONS = 2,
  parameter int VALUE_WIDTH = 12,
  parameter logic [NUM_REGIONS*VALUE_WIDTH-1:0] REGION_MIN_X = {12'd361, 12'd0},
  parameter logic [NUM_REGIONS*VALUE_WIDTH-1:0] REGION_MAX_X = {12'd661, 12'd1023},
  parameter logic [NUM_REGIONS*VALUE_WIDTH-1:0] REGION_MIN_Y = {12'd367, 12'd0},
  parameter logic [NUM_REGIONS*VALUE_WIDTH-1:0] REGION_MAX_Y = {12'd667, 12'd767},
  parameter int GAP_CYCLES = 3,
  parameter int RECENTRE = 1,
  localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       region_sel,
  input  logic                   reload,
  output logic                   setmin_x,
  output logic                   setmax_x,
  output logic                   setmin_y,
  output logic                   setmax_y,
  output logic                   setx,
  output logic                   sety,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic [SEL_W-1:0]       active_region,
  output logic                   sel_error
);

  localparam int NSLOT = 1 << SEL_W;
  localparam int NWR = (RECENTRE != 0) ? 6 : 4;
  localparam logic [2:0] LAST_IDX = 3'(NWR - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [SEL_W:0] NREG = (SEL_W + 1)'(NUM_REGIONS);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

  state_t state, nxt_state;

  logic [VALUE_WIDTH-1:0] min_x_a [NSLOT];
  logic [VALUE_WIDTH-1:0] max_x_a [NSLOT];
  logic [VALUE_WIDTH-1:0] min_y_a [NSLOT];
  logic [VALUE_WIDTH-1:0] max_y_a [NSLOT];
  logic [VALUE_WIDTH-1:0] cx_a    [NSLOT];
  logic [VALUE_WIDTH-1:0] cy_a    [NSLOT];

  // Unused slots up to the next power of two read as zero so the selector never indexes past the table.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NUM_REGIONS) begin : g_real
      assign min_x_a[i] = REGION_MIN_X[i*VALUE_WIDTH +: VALUE_WIDTH];
      assign max_x_a[i] = REGION_MAX_X[i*VALUE_WIDTH +: VALUE_WIDTH];
      assign min_y_a[i] = REGION_MIN_Y[i*VALUE_WIDTH +: VALUE_WIDTH];
      assign max_y_a[i] = REGION_MAX_Y[i*VALUE_WIDTH +: VALUE_WIDTH];
      assign cx_a[i] = VALUE_WIDTH'(({1'b0, min_x_a[i]} + {1'b0, max_x_a[i]}) >> 1);
      assign cy_a[i] = VALUE_WIDTH'(({1'b0, min_y_a[i]} + {1'b0, max_y_a[i]}) >> 1);
    end else begin : g_pad
      assign min_x_a[i] = '0;
      assign max_x_a[i] = '0;
      assign min_y_a[i] = '0;
      assign max_y_a[i] = '0;
      assign cx_a[i]    = '0;
      assign cy_a[i]    = '0;
    end
  end

  logic [SEL_W-1:0] target;
  logic [2:0]       wr_idx;
  logic [3:0]       gap_cnt;
  logic             pending;
  logic             init_req;
  logic             err_hold;

  logic             in_range, last_wr, idle_req, busy_req;
  logic             start, advance, enter_gap, set_pend, oor_req;
  logic [SEL_W-1:0] start_sel, ld_sel;
  logic [2:0]       ld_idx;
  logic [VALUE_WIDTH-1:0] ld_val;

  assign in_range = ({1'b0, region_sel} < NREG);
  assign last_wr  = (wr_idx == LAST_IDX);
  // Once an out-of-range selection has been flagged, holding it does not re-flag every cycle.
  assign idle_req = reload | ((region_sel != active_region) & (in_range | ~err_hold));
  assign busy_req = reload | ((region_sel != target) & (in_range | ~err_hold));

  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    start_sel = region_sel;
    advance   = 1'b0;
    enter_gap = 1'b0;
    set_pend  = 1'b0;
    oor_req   = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_req) begin
          start     = 1'b1;
          start_sel = '0;
          nxt_state = S_WRITE;
        end else if (idle_req) begin
          if (in_range) begin
            start     = 1'b1;
            nxt_state = S_WRITE;
          end else begin
            oor_req = 1'b1;
          end
        end
      end
      S_WRITE, S_GAP: begin
        if (busy_req) begin
          set_pend = in_range;
          oor_req  = ~in_range;
        end
        if (state == S_WRITE) begin
          if (GAP_CYCLES != 0) begin
            nxt_state = last_wr ? S_GAP : S_GAP;
            enter_gap = 1'b1;
          end else if (last_wr) begin
            nxt_state = S_DONE;
          end else begin
            advance = 1'b1;
          end
        end else if (gap_cnt == 4'd0) begin
          if (last_wr) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_WRITE;
            advance   = 1'b1;
          end
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        if (pending | busy_req) begin
          if (in_range) begin
            start     = 1'b1;
            nxt_state = S_WRITE;
          end else begin
            oor_req = 1'b1;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign ld_sel = start ? start_sel : target;
  assign ld_idx = start ? 3'd0 : 3'(wr_idx + 3'd1);

  always_comb begin
    ld_val = '0;
    case (ld_idx)
      3'd0:    ld_val = min_x_a[ld_sel];
      3'd1:    ld_val = max_x_a[ld_sel];
      3'd2:    ld_val = min_y_a[ld_sel];
      3'd3:    ld_val = max_y_a[ld_sel];
      3'd4:    ld_val = cx_a[ld_sel];
      default: ld_val = cy_a[ld_sel];
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state         <= S_IDLE;
      target        <= '0;
      wr_idx        <= '0;
      gap_cnt       <= '0;
      value         <= '0;
      active_region <= '0;
      pending       <= 1'b0;
      init_req      <= 1'b1;
      err_hold      <= 1'b0;
      sel_error     <= 1'b0;
    end else begin
      state    <= nxt_state;
      init_req <= 1'b0;
      if (start || advance) begin
        value  <= ld_val;
        wr_idx <= ld_idx;
      end
      if (start) target <= start_sel;
      if (enter_gap) gap_cnt <= GAP_LOAD;
      else if (state == S_GAP) gap_cnt <= gap_cnt - 4'd1;
      if (nxt_state == S_DONE) active_region <= target;
      if (state == S_DONE) pending <= 1'b0;
      else if (set_pend) pending <= 1'b1;
      sel_error <= oor_req;
      if (oor_req) err_hold <= 1'b1;
      else if (in_range) err_hold <= 1'b0;
    end
  end

  assign busy     = (state == S_WRITE) || (state == S_GAP);
  assign done     = (state == S_DONE);
  assign setmin_x = (state == S_WRITE) && (wr_idx == 3'd0);
  assign setmax_x = (state == S_WRITE) && (wr_idx == 3'd1);
  assign setmin_y = (state == S_WRITE) && (wr_idx == 3'd2);
  assign setmax_y = (state == S_WRITE) && (wr_idx == 3'd3);
  assign setx     = (state == S_WRITE) && (wr_idx == 3'd4);
  assign sety     = (state == S_WRITE) && (wr_idx == 3'd5);

endmodule

// File: doc/mouse_region_ctl.md
MOUSE_REGION_CTL -- requirements
Module: mouse_region_ctl

Interface
REQ-001 Parameter NUM_REGIONS, default 2: number of selectable cursor regions, range 1..16.
REQ-002 Parameter VALUE_WIDTH, default 12: coordinate width.
REQ-003 Parameter REGION_MIN_X, REGION_MAX_X, REGION_MIN_Y, REGION_MAX_Y, each NUM_REGIONS*VALUE_WIDTH bits: packed bounds, region i in slice [i*VALUE_WIDTH +: VALUE_WIDTH]. Defaults: region0 = 0..1023 x 0..767; region1 = 361..661 x 367..667.
REQ-004 Parameter GAP_CYCLES, default 3: idle cycles after each write strobe, range 0..15.
REQ-005 Parameter RECENTRE, default 1: when 1, append cursor set-x and set-y writes to each sequence.
REQ-006 SEL_W = max(1, clog2(NUM_REGIONS)), derived locally.
REQ-007 Clock and reset: one clock, pclk; rst is synchronous and active-high.
REQ-008 pclk  input  1  pixel clock; all logic on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 region_sel  input  SEL_W  requested region index.
REQ-011 reload  input  1  one-cycle pulse; reprogram the current region.
REQ-012 setmin_x, setmax_x, setmin_y, setmax_y, setx, sety  output  1 each  one-cycle write strobes to the mouse controller.
REQ-013 value  output  VALUE_WIDTH  data qualifying the strobes.
REQ-014 busy  output  1  sequence in progress.
REQ-015 done  output  1  one-cycle pulse at sequence completion.
REQ-016 active_region  output  SEL_W  last fully programmed region.
REQ-017 sel_error  output  1  one-cycle pulse on out-of-range request.

Function
REQ-018 A request is raised in cycle t when reload=1, or when region_sel != active_region and no sequence is active; both together = one request.
REQ-019 States: IDLE, WRITE, GAP, DONE; IDLE->WRITE on request; WRITE->GAP (or next WRITE if GAP_CYCLES=0); GAP->WRITE when gap counter expires and writes remain; last gap->DONE; DONE->IDLE, or DONE->WRITE if a request is pending.
REQ-020 The target index is latched in cycle t; write order: setmin_x, setmax_x, setmin_y, setmax_y, then setx, sety if RECENTRE=1 (W = 4 or 6 writes).
REQ-021 Write k (k=0..W-1) strobes in cycle t+1+k*(GAP_CYCLES+1); exactly one strobe is high in any cycle.
REQ-022 value carries that write's data in the strobe cycle and holds it until the next strobe.
REQ-023 setx/sety data = (min+max)>>1, summed in VALUE_WIDTH+1 bits, truncated to VALUE_WIDTH.
REQ-024 busy is high from cycle t+1 through the final gap cycle.
REQ-025 done pulses, and active_region takes the target value, in cycle t+1+W*(GAP_CYCLES+1).
REQ-026 A reload, or a region_sel differing from the target, while busy sets one pending flag; requests merge and the sequence is never aborted.
REQ-027 A pending request starts in the DONE cycle, using region_sel sampled in that cycle; the next first strobe occurs in the following cycle.
REQ-028 A request with region_sel >= NUM_REGIONS pulses sel_error for one cycle, starts no sequence, sets no pending flag, and leaves active_region unchanged.
REQ-029 Without a request, all strobes stay low and value holds its last written data.

Reset
REQ-030 While rst=1: all strobes=0, value=0, busy=0, done=0, sel_error=0, active_region=0, pending cleared, state IDLE.
REQ-031 rst asserted mid-sequence aborts it at the next edge; no partial completion is signalled.
REQ-032 The first cycle with rst=0 is an implicit request for region 0, so the first setmin_x strobe occurs in the second cycle after reset release.

Verification
REQ-033 Defaults; release rst at cycle 0 -> setmin_x value=0 at cycle 1, setmax_x=1023 at 5, setmin_y=0 at 9, setmax_y=767 at 13, setx=511 at 17, sety=383 at 21; done at 25, busy low at 25.
REQ-034 Idle, region_sel 0->1 at cycle t -> strobes at t+1..t+21 step 4 with values 361, 661, 367, 667, 511, 517; active_region=1 at t+25.
REQ-035 region_sel toggled 1->0->1 while busy -> current sequence completes unaltered; one further sequence for region 1 starts in the DONE cycle, first strobe one cycle later.
REQ-036 NUM_REGIONS=3, region_sel=3 -> sel_error one cycle, no strobes, active_region unchanged.
REQ-037 rst asserted during the third write -> all outputs 0 the next cycle; after release, the full region-0 sequence is replayed per REQ-032.
REQ-038 GAP_CYCLES=0, RECENTRE=0, reload pulse -> four strobes on consecutive cycles t+1..t+4, done at t+5.
